// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and the datapath it steers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state enum, opcode constants, ALUOp/ALUSrcB/PCSource encodings,
//           the bundled control-word struct and the DECODE dispatch helper.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDI_EX  = 4'd9,
    ST_ADDI_WB  = 4'd10,
    ST_JUMP     = 4'd11,
    ST_ERROR    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       not_op;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       error;
  } ctrl_t;

  // Instruction-class dispatch out of DECODE; unknown opcodes trap.
  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:   decode_next = ST_MEM_ADDR;
      OP_RTYPE:       decode_next = ST_EXEC;
      OP_BEQ, OP_BNE: decode_next = ST_BRANCH;
      OP_ADDI:        decode_next = ST_ADDI_EX;
      OP_J:           decode_next = ST_JUMP;
      default:        decode_next = ST_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and its datapath.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stretches FETCH/MEM_RD/MEM_WR.
// master = controller (reads opcode/mem_ready, drives selects, enables, debug);
// slave  = datapath side (the reverse).
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             NotOp;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemToReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             error;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, NotOp, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           error, state_dbg, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, NotOp, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           error, state_dbg, retired
  );
endinterface

// File: rtl/multicycle_ctrl_out.sv
// Combinational state-to-control-word decoder for the multicycle controller.
// Latency: 0 cycles (pure combinational from state/opcode/mem_ready).
// Backpressure: mem_ready only gates IRWrite/PCWrite in FETCH.
// Ports: rst_n (forces all-zero word while low), state, opcode, mem_ready -> ctrl.
module multicycle_ctrl_out
  import cpu_ctrl_pkg::*;
(
  input  logic       rst_n,
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          ctrl.mem_read = 1'b1;
          // PC+4 runs through the ALU every fetch cycle, but IR/PC only load
          // on the cycle memory actually returns the word.
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        ST_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        ST_MEM_ADDR, ST_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        ST_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        ST_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        ST_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        ST_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        ST_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.not_op        = (opcode == OP_BNE);
        end
        ST_ADDI_WB: begin
          ctrl.reg_write = 1'b1;
        end
        ST_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        ST_ERROR: begin
          ctrl.error = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, next-state logic, retired counter.
// Latency: lw 5, sw/R/addi 4, beq/bne/j 3 cycles; +1 per mem_ready=0 cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with request asserted until mem_ready.
// Ports: clock, reset (sync, active-low), bus (master modport: opcode/mem_ready in,
//        datapath selects/enables, error, state_dbg, retired out).
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    case (state_q)
      ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE:   state_d = decode_next(bus.opcode);
      ST_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:     state_d = ST_R_WB;
      ST_ADDI_EX:  state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_ADDI_WB, ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_ERROR:    state_d = ST_ERROR;
      // Unused encodings are unreachable; trap rather than guess.
      default:     state_d = ST_ERROR;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  multicycle_ctrl_out u_ctrl_out (
    .rst_n     (reset),
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.NotOp       = ctrl.not_op;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.error       = ctrl.error;

  // Debug/count outputs read as reset values while reset is held, even before
  // the first clock edge has cleared the registers.
  assign bus.state_dbg = reset ? state_q : ST_FETCH;
  assign bus.retired   = reset ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (CNT_W=4 so the counter wrap is reachable).
// Latency: n/a.
// Backpressure: drives mem_ready wait cycles in FETCH/MEM_RD/MEM_WR.
module tb_multicycle_control;
  import cpu_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] model_ret;

  multicycle_control_if #(.CNT_W(4)) bus ();

  multicycle_control #(.CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] obs_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.NotOp, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.error};
  endfunction

  // Reference control word per step, straight from the controller's state table.
  function automatic logic [17:0] exp_ctrl(input state_e s, input logic rdy, input logic [5:0] op);
    logic pcw, pcwc, notop, iord, mrd, mwr, irw, m2r, rdst, rw, srca, err;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, notop, iord, mrd, mwr, irw, m2r, rdst, rw, srca, err} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    case (s)
      ST_FETCH:    begin mrd = 1; srcb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      ST_DECODE:   srcb = 2'b11;
      ST_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; iord = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mwr = 1; iord = 1; end
      ST_EXEC:     begin srca = 1; aluop = 2'b10; end
      ST_R_WB:     begin rw = 1; rdst = 1; end
      ST_BRANCH:   begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; notop = (op == 6'b000101); end
      ST_ADDI_EX:  begin srca = 1; srcb = 2'b10; end
      ST_ADDI_WB:  rw = 1;
      ST_JUMP:     begin pcw = 1; pcsrc = 2'b10; end
      ST_ERROR:    err = 1;
      default:     err = 0;
    endcase
    return {pcw, pcwc, notop, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, err};
  endfunction

  // One clock step: drive inputs, check the expected state/outputs/count, advance.
  task automatic step(input state_e st, input logic rdy, input logic [5:0] op);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
    check($sformatf("state@%s", st.name()), 32'(bus.state_dbg), 32'(st));
    check($sformatf("ctrl@%s", st.name()), 32'(obs_ctrl()), 32'(exp_ctrl(st, rdy, op)));
    check($sformatf("retired@%s", st.name()), 32'(bus.retired), 32'(model_ret));
    @(posedge clock);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  // Walks one legal instruction through its expected step sequence.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) step(ST_FETCH, 1'b0, rop());
    step(ST_FETCH, 1'b1, rop());
    step(ST_DECODE, rbit(), op);
    case (op)
      6'b100011: begin
        step(ST_MEM_ADDR, rbit(), op);
        for (int i = 0; i < wm; i++) step(ST_MEM_RD, 1'b0, op);
        step(ST_MEM_RD, 1'b1, op);
        step(ST_MEM_WB, rbit(), op);
      end
      6'b101011: begin
        step(ST_MEM_ADDR, rbit(), op);
        for (int i = 0; i < wm; i++) step(ST_MEM_WR, 1'b0, op);
        step(ST_MEM_WR, 1'b1, op);
      end
      6'b000000: begin step(ST_EXEC, rbit(), op); step(ST_R_WB, rbit(), op); end
      6'b000100, 6'b000101: step(ST_BRANCH, rbit(), op);
      6'b001000: begin step(ST_ADDI_EX, rbit(), op); step(ST_ADDI_WB, rbit(), op); end
      default: step(ST_JUMP, rbit(), op);
    endcase
    model_ret = model_ret + 4'd1;
  endtask

  task automatic reset_check(input string tag);
    #1;
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'd0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'(ST_FETCH));
    check({tag, "_retired"}, 32'(bus.retired), 32'd0);
  endtask

  initial begin
    logic [5:0] legal [7];
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    checks = 0;
    errors = 0;
    model_ret = 4'd0;

    // Reset held for three edges with inputs wiggling.
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b100011;
    reset_check("rst0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      bus.mem_ready = rbit();
      bus.opcode = rop();
      reset_check("rst");
    end
    #1;
    reset = 1'b1;

    // Directed: lw, sw with 3 write waits, bne, beq, addi, R-type, j.
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b000000, 2, 0);
    run_instr(6'b000010, 0, 0);

    // Random mix with random memory waits.
    for (int n = 0; n < 40; n++)
      run_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Illegal opcode traps and stays trapped.
    step(ST_FETCH, 1'b1, rop());
    step(ST_DECODE, rbit(), 6'b111111);
    for (int i = 0; i < 12; i++) step(ST_ERROR, rbit(), rop());

    // Reset clears the trap on the next edge.
    reset = 1'b0;
    reset_check("trap_rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_ret = 4'd0;

    // Sixteen retirements wrap the 4-bit counter back to zero.
    for (int n = 0; n < 16; n++) run_instr(6'b000010, 0, 0);
    #1;
    check("wrap", 32'(bus.retired), 32'd0);
    run_instr(6'b000010, 0, 0);
    #1;
    check("after_wrap", 32'(bus.retired), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
